// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - in-order register write-back queue with read-port forwarding for the LC-3b regfile
// Optional macro WBQ_BYPASS_EN: a request arriving at an empty, unstalled queue goes straight to the write port.
module reg_wb_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [REG_W-1:0]         enq_dest,
   input  logic [DATA_W-1:0]        enq_data,
   input  logic                     wb_stall,
   output logic                     wb_load,
   output logic [REG_W-1:0]         wb_dest,
   output logic [DATA_W-1:0]        wb_data,
   input  logic [REG_W-1:0]         fwd_src_a,
   input  logic [REG_W-1:0]         fwd_src_b,
   output logic                     fwd_hit_a,
   output logic [DATA_W-1:0]        fwd_data_a,
   output logic                     fwd_hit_b,
   output logic [DATA_W-1:0]        fwd_data_b,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [REG_W-1:0]  dest_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count_q;
   logic [PTR_W-1:0]  fwd_idx;
   logic              do_enq;
   logic              do_pop;
   logic              bypass;

   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign enq_ready = (count_q != CNT_W'(DEPTH));
   assign do_pop    = !empty && !wb_stall;

`ifdef WBQ_BYPASS_EN
   assign bypass = empty && enq_valid && !wb_stall;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed request is consumed by the write port and never stored.
   assign do_enq = enq_valid && enq_ready && !bypass;

   always_comb begin
      wb_load = do_pop || bypass;
      wb_dest = '0;
      wb_data = '0;
      if (!empty) begin
         wb_dest = dest_mem[head];
         wb_data = data_mem[head];
      end else if (bypass) begin
         wb_dest = enq_dest;
         wb_data = enq_data;
      end
   end

   // Walk oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;
      fwd_idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            if (dest_mem[fwd_idx] == fwd_src_a) begin
               fwd_hit_a  = 1'b1;
               fwd_data_a = data_mem[fwd_idx];
            end
            if (dest_mem[fwd_idx] == fwd_src_b) begin
               fwd_hit_b  = 1'b1;
               fwd_data_b = data_mem[fwd_idx];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (do_enq) tail <= tail + PTR_W'(1);
         if (do_pop) head <= head + PTR_W'(1);
         case ({do_enq, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage is qualified by count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         dest_mem[tail] <= enq_dest;
         data_mem[tail] <= enq_data;
      end
   end

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb/tb_reg_wb_queue.sv - scoreboard bench for reg_wb_queue (optionally built with WBQ_BYPASS_EN)
module tb_reg_wb_queue;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        enq_valid;
   logic        enq_ready;
   logic [2:0]  enq_dest;
   logic [15:0] enq_data;
   logic        wb_stall;
   logic        wb_load;
   logic [2:0]  wb_dest;
   logic [15:0] wb_data;
   logic [2:0]  fwd_src_a;
   logic [2:0]  fwd_src_b;
   logic        fwd_hit_a;
   logic [15:0] fwd_data_a;
   logic        fwd_hit_b;
   logic [15:0] fwd_data_b;
   logic [2:0]  count;
   logic        empty;

   typedef struct {
      logic [2:0]  dest;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   reg_wb_queue #(.DEPTH(4), .DATA_W(16), .REG_W(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_dest(enq_dest), .enq_data(enq_data),
      .wb_stall(wb_stall), .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data),
      .fwd_src_a(fwd_src_a), .fwd_src_b(fwd_src_b),
      .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
      .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
      .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every regfile write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset_n && wb_load) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got dest=%0d data=0x%0h with no write expected", wb_dest, wb_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_dest", {29'd0, wb_dest}, {29'd0, e.dest});
            chk("wb_data", {16'd0, wb_data}, {16'd0, e.data});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic enq(input logic [2:0] d, input logic [15:0] v, input bit accepted);
      enq_valid = 1'b1;
      enq_dest  = d;
      enq_data  = v;
      if (accepted) sb.push_back('{dest: d, data: v});
   endtask

   task automatic idle();
      enq_valid = 1'b0;
      enq_dest  = '0;
      enq_data  = '0;
   endtask

   initial begin
      reset_n   = 1'b0;
      wb_stall  = 1'b0;
      fwd_src_a = 3'd0;
      fwd_src_b = 3'd0;
      idle();

      // Reset state
      neg();
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_wb_load", wb_load, 0);
      chk("rst_enq_ready", enq_ready, 1);
      chk("rst_fwd_hit_a", fwd_hit_a, 0);
      chk("rst_fwd_data_a", fwd_data_a, 0);
      cyc();
      reset_n = 1'b1;
      cyc();

      // Single write
      enq(3'd3, 16'h1234, 1'b1);
      neg();
`ifdef WBQ_BYPASS_EN
      chk("single_bypass_load", wb_load, 1);
      chk("single_bypass_count", count, 0);
      cyc();
      idle();
      neg();
      chk("single_empty", empty, 1);
      chk("single_load_after", wb_load, 0);
`else
      chk("single_load_n", wb_load, 0);
      cyc();
      idle();
      neg();
      chk("single_load_n1", wb_load, 1);
      chk("single_count_n1", count, 1);
      cyc();
      neg();
      chk("single_empty", empty, 1);
      chk("single_load_after", wb_load, 0);
`endif

      // Fill under stall; pointers start at 1 so the tail wraps
      wb_stall = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         enq(3'(k), 16'(k), 1'b1);
         cyc();
      end
      enq(3'd7, 16'h0005, 1'b0);
      fwd_src_a = 3'd4;
      fwd_src_b = 3'd0;
      neg();
      chk("full_count", count, 4);
      chk("full_enq_ready", enq_ready, 0);
      chk("full_stall_load", wb_load, 0);
      chk("full_fwd_hit_a", fwd_hit_a, 1);
      chk("full_fwd_data_a", fwd_data_a, 16'h0004);
      chk("full_fwd_hit_b", fwd_hit_b, 0);
      cyc();
      idle();
      neg();
      chk("full_ignored_count", count, 4);
      wb_stall = 1'b0;
      repeat (4) cyc();
      neg();
      chk("drain_empty", empty, 1);

      // Refill across the wrap point
      wb_stall = 1'b1;
      enq(3'd5, 16'h0011, 1'b1); cyc();
      enq(3'd6, 16'h0012, 1'b1); cyc();
      enq(3'd7, 16'h0013, 1'b1); cyc();
      enq(3'd0, 16'h0014, 1'b1); cyc();
      idle();
      neg();
      chk("refill_count", count, 4);
      wb_stall = 1'b0;
      repeat (4) cyc();
      neg();
      chk("refill_empty", empty, 1);

      // Youngest-match forwarding; in-flight request is invisible
      wb_stall = 1'b1;
      fwd_src_a = 3'd2;
      fwd_src_b = 3'd5;
      enq(3'd2, 16'hAAAA, 1'b1); cyc();
      enq(3'd2, 16'hBBBB, 1'b1); cyc();
      enq(3'd5, 16'h5555, 1'b1);
      neg();
      chk("fwd_young_hit_a", fwd_hit_a, 1);
      chk("fwd_young_data_a", fwd_data_a, 16'hBBBB);
      chk("fwd_incoming_hit_b", fwd_hit_b, 0);
      chk("fwd_incoming_data_b", fwd_data_b, 0);
      cyc();
      idle();
      neg();
      chk("fwd_stored_hit_b", fwd_hit_b, 1);
      chk("fwd_stored_data_b", fwd_data_b, 16'h5555);
      wb_stall = 1'b0;
      cyc();
      neg();
      chk("fwd_popping_load", wb_load, 1);
      chk("fwd_popping_hit_a", fwd_hit_a, 1);
      chk("fwd_popping_data_a", fwd_data_a, 16'hBBBB);
      cyc();
      neg();
      chk("fwd_drained_hit_a", fwd_hit_a, 0);
      chk("fwd_drained_data_a", fwd_data_a, 0);
      cyc();
      neg();
      chk("fwd_drained_hit_b", fwd_hit_b, 0);

      // Simultaneous enqueue and pop
      wb_stall = 1'b1;
      enq(3'd1, 16'h0101, 1'b1); cyc();
      enq(3'd2, 16'h0202, 1'b1); cyc();
      wb_stall = 1'b0;
      enq(3'd3, 16'h0303, 1'b1);
      neg();
      chk("sim_count_before", count, 2);
      chk("sim_load", wb_load, 1);
      cyc();
      idle();
      wb_stall = 1'b1;
      neg();
      chk("sim_count_after", count, 2);
      chk("sim_head_dest", wb_dest, 2);
      chk("sim_head_data", wb_data, 16'h0202);
      enq(3'd4, 16'h0404, 1'b1); cyc();
      enq(3'd5, 16'h0505, 1'b1); cyc();
      wb_stall = 1'b0;
      enq(3'd6, 16'h0606, 1'b0);
      neg();
      chk("simfull_enq_ready", enq_ready, 0);
      chk("simfull_load", wb_load, 1);
      cyc();
      idle();
      wb_stall = 1'b1;
      neg();
      chk("simfull_count", count, 3);
      wb_stall = 1'b0;
      repeat (3) cyc();
      neg();
      chk("simfull_empty", empty, 1);

      // Stall hold
      wb_stall = 1'b1;
      enq(3'd6, 16'h6666, 1'b1);
      cyc();
      idle();
      for (int i = 0; i < 5; i++) begin
         neg();
         chk("hold_load", wb_load, 0);
         chk("hold_dest", wb_dest, 6);
         chk("hold_data", wb_data, 16'h6666);
         cyc();
      end
      wb_stall = 1'b0;
      neg();
      chk("hold_release_load", wb_load, 1);
      cyc();
      neg();
      chk("hold_empty", empty, 1);

      // Reset mid-stream with three pending writes
      wb_stall = 1'b1;
      fwd_src_a = 3'd1;
      enq(3'd1, 16'h0A01, 1'b1); cyc();
      enq(3'd2, 16'h0A02, 1'b1); cyc();
      enq(3'd3, 16'h0A03, 1'b1); cyc();
      idle();
      neg();
      chk("pre_rst_count", count, 3);
      chk("pre_rst_hit_a", fwd_hit_a, 1);
      cyc();
      reset_n  = 1'b0;
      wb_stall = 1'b0;
      sb.delete();
      #1;
      chk("midrst_count", count, 0);
      chk("midrst_empty", empty, 1);
      chk("midrst_load", wb_load, 0);
      chk("midrst_hit_a", fwd_hit_a, 0);
      cyc();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         neg();
         chk("post_rst_load", wb_load, 0);
         cyc();
      end

      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Writer-side front end for the 8-entry LC-3b register file.
- Buffers register write requests (dest, data) from execute/memory units in a small FIFO.
- Drains them in order, one per cycle, onto the regfile's single write port (load/dest/in).
- Provides same-cycle forwarding of pending (not yet written) values to the two read-port addresses, so decode sees the youngest value.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >= 2)
- DATA_W, 16, write data width (lc3b_word)
- REG_W, 3, register index width (lc3b_reg)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- enq_valid  in  1  write request present
- enq_ready  out  1  queue can accept a request this cycle
- enq_dest  in  REG_W  destination register of request
- enq_data  in  DATA_W  data of request
- wb_stall  in  1  hold drain; no regfile write this cycle
- wb_load  out  1  to regfile load
- wb_dest  out  REG_W  to regfile dest
- wb_data  out  DATA_W  to regfile in
- fwd_src_a  in  REG_W  read address A (same as regfile src_a)
- fwd_src_b  in  REG_W  read address B
- fwd_hit_a  out  1  pending write to fwd_src_a exists
- fwd_data_a  out  DATA_W  youngest pending data for fwd_src_a
- fwd_hit_b  out  1  pending write to fwd_src_b exists
- fwd_data_b  out  DATA_W  youngest pending data for fwd_src_b
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

Behaviour:
- Reset (async, reset_n=0): head/tail pointers = 0, count = 0, empty = 1, wb_load = 0, fwd_hit_a/b = 0, fwd_data_a/b = 0, enq_ready = 1. Entry storage is not cleared. Reset mid-operation discards all pending writes; no partial write reaches the regfile.
- Enqueue: occurs on a rising edge when enq_valid && enq_ready. Entry is written at tail and tail is incremented modulo DEPTH.
- enq_ready = (count != DEPTH). There is no enqueue-while-full pass-through, even if a pop happens in the same cycle.
- Drain (combinational outputs):
  - wb_load = !empty && !wb_stall.
  - wb_dest/wb_data = head entry whenever !empty; 0 when empty.
  - Pop on the edge where wb_load = 1. The regfile captures the value on the same edge.
- Latency without bypass: enqueue at edge N -> wb_load high during cycle N+1 at the earliest.
- Ordering: strict FIFO. Two writes to the same register reach the regfile in enqueue order.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Full: count = DEPTH, enq_ready = 0, enq_valid ignored.
- Empty + wb_stall: no effect.
- Pointer wrap: pointers wrap modulo DEPTH. count distinguishes full from empty.
- Forwarding (combinational over valid entries):
  - Hit when any valid entry's dest equals the src address. Data comes from the youngest matching entry (closest to tail).
  - The head entry being popped this cycle still counts as pending.
  - An incoming enq_* request in the current cycle is not visible to forwarding.
  - No hit: fwd_hit = 0, fwd_data = 0.
  - A and B are evaluated independently; both may hit the same entry.

Optional Feature:
- Macro: WBQ_BYPASS_EN.
- Defined: when empty && enq_valid && !wb_stall, the request goes straight to the write port in the same cycle (wb_load=1, wb_dest=enq_dest, wb_data=enq_data) and is not stored; count stays 0. enq_ready is unchanged by bypass.
- Not defined: wb_* is driven only from stored entries; minimum latency is 1 cycle.

Test Plan:
- Reset: assert reset_n=0 mid-stream with count=3 -> immediately count=0, empty=1, wb_load=0, fwd_hit_a=0; after release no stale writes appear.
- Single write: enqueue dest=R3, data=0x1234 into empty queue -> next cycle wb_load=1, wb_dest=3, wb_data=0x1234; following cycle empty=1. With WBQ_BYPASS_EN: wb_load=1 in the enqueue cycle.
- Fill/full/wrap: enqueue R1..R4 with data 0x0001..0x0004 while wb_stall=1 -> count=4, enq_ready=0, 5th request ignored. Release stall -> four writes in order 1,2,3,4. Refill 4 more -> correct order across pointer wrap.
- Youngest forwarding: queue R2=0xAAAA then R2=0xBBBB with stall, fwd_src_a=2, fwd_src_b=5 -> fwd_hit_a=1, fwd_data_a=0xBBBB, fwd_hit_b=0, fwd_data_b=0. After both drain -> fwd_hit_a=0.
- Simultaneous enqueue/pop at count=2 -> count stays 2 and head advances. Simultaneous enqueue at count=4 with pop -> enqueue rejected, count=3.
- Stall hold: with count=1 and wb_stall=1 for 5 cycles -> wb_load=0 throughout, wb_dest/wb_data stable; drains on the first unstalled cycle.
